// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main controller: sequences fetch/decode/execute/memory/writeback
// and drives datapath selects and strobes, with a timed handshake to unified memory.
module multicycle_control #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [5:0] Opcode,
    input  logic       MemReady,
    input  logic       Stall,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       MemtoReg,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] PCSource,
    output logic       BusError,
    output logic       IllegalOp
);

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_MEMADR = 4'd3,
        ST_MEMRD  = 4'd4,
        ST_MEMWB  = 4'd5,
        ST_MEMWR  = 4'd6,
        ST_REXEC  = 4'd7,
        ST_RWB    = 4'd8,
        ST_IEXEC  = 4'd9,
        ST_IWB    = 4'd10,
        ST_BRANCH = 4'd11,
        ST_JUMP   = 4'd12,
        ST_ERR    = 4'd13
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);
    localparam logic [5:0]       OP_SW    = 6'b101011;

    function automatic state_t decode_op(input logic [5:0] op);
        case (op)
            6'b000000:                      decode_op = ST_REXEC;
            6'b100011, 6'b101011:           decode_op = ST_MEMADR;
            6'b000100:                      decode_op = ST_BRANCH;
            6'b000010:                      decode_op = ST_JUMP;
            6'b001000, 6'b001001, 6'b001100, 6'b001101,
            6'b001110, 6'b001010, 6'b001011: decode_op = ST_IEXEC;
            default:                        decode_op = ST_ERR;
        endcase
    endfunction

    state_t           state_r;
    state_t           next_raw_s;
    state_t           next_state_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_step_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic             timeout_raw_s;
    logic             timeout_s;
    logic             hold_s;
    logic             bus_err_r;
    logic             accept_s;

    // Next-state and wait-counter logic; a stall freezes everything except IDLE and ERR.
    always_comb begin
        next_raw_s    = state_r;
        cnt_step_s    = cnt_r;
        timeout_raw_s = 1'b0;
        hold_s        = Stall && (state_r != ST_IDLE) && (state_r != ST_ERR);
        case (state_r)
            ST_IDLE:   next_raw_s = ST_FETCH;
            ST_FETCH, ST_MEMRD, ST_MEMWR: begin
                if (MemReady) begin
                    if (state_r == ST_FETCH) begin
                        next_raw_s = ST_DECODE;
                    end else if (state_r == ST_MEMRD) begin
                        next_raw_s = ST_MEMWB;
                    end else begin
                        next_raw_s = ST_FETCH;
                    end
                end else if (cnt_r == CNT_LAST) begin
                    next_raw_s    = ST_ERR;
                    timeout_raw_s = 1'b1;
                end else begin
                    cnt_step_s = cnt_r + CNT_W'(1);
                end
            end
            ST_DECODE: next_raw_s = decode_op(Opcode);
            ST_MEMADR: begin
                if (Opcode == OP_SW) begin
                    next_raw_s = ST_MEMWR;
                end else begin
                    next_raw_s = ST_MEMRD;
                end
            end
            ST_MEMWB:  next_raw_s = ST_FETCH;
            ST_REXEC:  next_raw_s = ST_RWB;
            ST_RWB:    next_raw_s = ST_FETCH;
            ST_IEXEC:  next_raw_s = ST_IWB;
            ST_IWB:    next_raw_s = ST_FETCH;
            ST_BRANCH: next_raw_s = ST_FETCH;
            ST_JUMP:   next_raw_s = ST_FETCH;
            ST_ERR:    next_raw_s = ST_FETCH;
            default:   next_raw_s = ST_IDLE;
        endcase

        timeout_s = timeout_raw_s && !hold_s;
        if (hold_s) begin
            next_state_s = state_r;
            cnt_next_s   = cnt_r;
        end else if (next_raw_s != state_r) begin
            next_state_s = next_raw_s;
            cnt_next_s   = '0;
        end else begin
            next_state_s = next_raw_s;
            cnt_next_s   = cnt_step_s;
        end
    end

    // State, wait counter and the ERR-cause flag (timeout vs. illegal opcode).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r   <= ST_IDLE;
            cnt_r     <= '0;
            bus_err_r <= 1'b0;
        end else begin
            state_r   <= next_state_s;
            cnt_r     <= cnt_next_s;
            bus_err_r <= timeout_s;
        end
    end

    assign accept_s = MemReady && !Stall;

    // Output decode from the state register; fetch strobes also need an accepted transfer.
    always_comb begin
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        MemtoReg    = 1'b0;
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 2'b00;
        PCSource    = 2'b00;
        BusError    = 1'b0;
        IllegalOp   = 1'b0;
        case (state_r)
            ST_IDLE: begin
            end
            ST_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = accept_s;
                PCWrite = accept_s;
            end
            ST_DECODE: ALUSrcB = 2'b11;
            ST_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
            end
            ST_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            ST_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
            end
            ST_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            ST_REXEC: begin
                ALUSrcA = 1'b1;
                ALUOp   = 2'b10;
            end
            ST_RWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
            end
            ST_IEXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                ALUOp   = 2'b11;
            end
            ST_IWB:    RegWrite = 1'b1;
            ST_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
            end
            ST_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
            end
            ST_ERR: begin
                BusError  = bus_err_r;
                IllegalOp = !bus_err_r;
            end
            default: begin
            end
        endcase
    end

endmodule
